// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// track_entry_t describes one in-flight instruction as seen by the
// forwarding logic; writes_reg() is the single definition of a
// "forwardable writer of this source" match.
package hazard_pkg;

  // Widest register address the tracking entries can hold. Narrower
  // AW values are zero-extended into this field.
  localparam int unsigned TRACK_AW    = 8;
  localparam int unsigned FWD_RF      = 0;
  localparam int unsigned STALL_CNT_W = 16;

  typedef struct packed {
    logic                valid;
    logic [TRACK_AW-1:0] rd;
    logic                regwrite;
    logic                memtoreg;
  } track_entry_t;

  // Register 0 is hardwired, so a write to it is never a producer.
  function automatic logic writes_reg(track_entry_t e, logic [TRACK_AW-1:0] src);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Nearest-writer priority search for one source operand.
//   src     : source register address (zero-extended to TRACK_AW)
//   ent     : tracking entries, index 0 is the youngest
//   hit     : some entry writes src
//   idx     : index of the youngest matching entry (valid when hit)
//   is_load : that entry is a load
module fwd_match_prio
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [TRACK_AW-1:0] src,
  input  track_entry_t        ent [DEPTH],
  output logic                hit,
  output logic [SEL_W-1:0]    idx,
  output logic                is_load
);

  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (!hit && writes_reg(ent[j], src)) begin
        hit     = 1'b1;
        idx     = SEL_W'(j);
        is_load = ent[j].memtoreg;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight destinations from execute (stage 0) onward, detects
// load-use hazards combinationally and registers per-operand forwarding
// selects as an instruction enters execute.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   id_*        : decode-stage instruction (valid, sources, rd, regwrite, load)
//   ext_hold    : freeze all state (memory wait)
//   flush       : kill decode and execute instructions
//   fwd_sel     : per-operand select for the execute instruction, 0 = regfile,
//                 k = stage-k result
//   stall       : hold PC and IF/ID, bubble into execute
//   stall_cnt   : saturating count of load-use stall cycles
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned AW         = 5,
  parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_rs,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memtoreg,
  input  logic                     ext_hold,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  // Stage DEPTH (the writeback stage) is never a forwarding or hazard
  // candidate, so only stages 0..DEPTH-1 are stored; an instruction
  // leaving stage DEPTH-1 simply drops out.
  track_entry_t entries_q [DEPTH];
  track_entry_t entries_d [DEPTH];
  // Stages that will become post-shift stages 1..DEPTH (index k-1);
  // a flushed execute instruction moves on invalidated.
  track_entry_t shift_view [DEPTH];
  track_entry_t id_entry;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d, sel_new;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0] st_hit, st_load;
  logic [SEL_W-1:0]   st_idx [NUM_SRC];
  logic [NUM_SRC-1:0] fw_hit, fw_load_unused;
  logic [SEL_W-1:0]   fw_idx [NUM_SRC];
  logic               enter;

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      shift_view[k] = entries_q[k];
    end
    if (flush) begin
      shift_view[0].valid = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [TRACK_AW-1:0] rs_ext;
    assign rs_ext = TRACK_AW'(id_rs[i*AW +: AW]);

    fwd_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_stall_match (
      .src     (rs_ext),
      .ent     (entries_q),
      .hit     (st_hit[i]),
      .idx     (st_idx[i]),
      .is_load (st_load[i])
    );

    fwd_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_match (
      .src     (rs_ext),
      .ent     (shift_view),
      .hit     (fw_hit[i]),
      .idx     (fw_idx[i]),
      .is_load (fw_load_unused[i])
    );
  end

  // A load at stage j has data on a result bus only once j+1 reaches
  // LOAD_STAGE; a nearer non-load writer shadows any older load.
  always_comb begin
    logic hazard;
    hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (st_hit[i] && st_load[i] && ((32'(st_idx[i]) + 32'd1) < LOAD_STAGE)) begin
        hazard = 1'b1;
      end
    end
    stall = hazard && id_valid && !flush;
  end

  // Pre-shift stage j becomes post-shift stage j+1.
  always_comb begin
    sel_new = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (fw_hit[i]) begin
        sel_new[i*SEL_W +: SEL_W] = fw_idx[i] + SEL_W'(1);
      end
    end
  end

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.rd       = TRACK_AW'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memtoreg = id_memtoreg;
  end

  assign enter = id_valid && !stall && !flush;

  always_comb begin
    entries_d   = entries_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (!ext_hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        entries_d[k] = shift_view[k-1];
      end
      entries_d[0] = enter ? id_entry : '0;
      fwd_sel_d    = enter ? sel_new : '0;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        entries_q[k] <= '0;
      end
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel   = fwd_sel_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memtoreg;
  logic        ext_hold;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  // Deep instance used for the saturation run: each self-dependent load
  // stalls 31 of every 32 cycles.
  logic        big_id_valid;
  logic [9:0]  big_id_rs;
  logic [4:0]  big_id_rd;
  logic        big_id_regwrite;
  logic        big_id_memtoreg;
  logic [11:0] big_fwd_sel;
  logic        big_stall;
  logic [15:0] big_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NUM_SRC(2), .DEPTH(2), .LOAD_STAGE(2), .AW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memtoreg (id_memtoreg),
    .ext_hold    (ext_hold),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  hazard_forward_unit #(.NUM_SRC(2), .DEPTH(32), .LOAD_STAGE(32), .AW(5)) big_dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (big_id_valid),
    .id_rs       (big_id_rs),
    .id_rd       (big_id_rd),
    .id_regwrite (big_id_regwrite),
    .id_memtoreg (big_id_memtoreg),
    .ext_hold    (1'b0),
    .flush       (1'b0),
    .fwd_sel     (big_fwd_sel),
    .stall       (big_stall),
    .stall_cnt   (big_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [4:0] rd, input logic rw, input logic m2r);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rd       = rd;
    id_regwrite = rw;
    id_memtoreg = m2r;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ext_hold = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);   // addi x3
    step();
    drive(1'b1, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1);   // lw x7,(x3)
    step();
    drive(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b1);   // lw x8,(x7): one stall
    step();
    step();
    drive(1'b1, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0);   // add x9,x8: stalling
    #1;
    n_cmp++; if (fwd_sel !== 4'b0010) begin n_bad++; $display("FAIL pre_reset_fwd_sel: got %b want %b", fwd_sel, 4'b0010); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL pre_reset_stall_cnt: got %0d want %0d", stall_cnt, 1); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stall: got %b want %b", stall, 1'b1); end
    reset = 1'b1;
    #1;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want %0d", stall_cnt, 0); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want %b", stall, 1'b0); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
    step();
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x5
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0101) begin n_bad++; $display("FAIL b2b_fwd_sel: got %b want %b", fwd_sel, 4'b0101); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt, 0); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
    step();
    drive(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall_first: got %b want %b", stall, 1'b1); end
    step();
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, 1); end
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL lu_bubble_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_second: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0010) begin n_bad++; $display("FAIL lu_fwd_sel: got %b want %b", fwd_sel, 4'b0010); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_nearest();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);   // addi x9
    step();
    step();                                        // addi x9 again
    drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0);   // or x1,x9,x9
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nearest_stall: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0101) begin n_bad++; $display("FAIL nearest_fwd_sel: got %b want %b", fwd_sel, 4'b0101); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reg0();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);   // ALU write to x0
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);   // reader of x0
    step();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL reg0_alu_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);   // load to x0
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);   // reader of x0
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reg0_load_stall: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL reg0_load_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reg0_stall_cnt: got %0d want %0d", stall_cnt, 0); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
    step();
    drive(1'b1, 5'd0, 5'd7, 5'd10, 1'b1, 1'b1);  // lw x10,(x7), flushed
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want %b", stall, 1'b0); end
    step();
    flush = 1'b0;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL flush_bubble_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, 0); end
    drive(1'b1, 5'd0, 5'd10, 5'd11, 1'b1, 1'b0); // reader of the killed x10
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_killed_stall: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL flush_killed_fwd_sel: got %b want %b", fwd_sel, 4'b0000); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);   // addi x3
    step();
    drive(1'b1, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1);   // lw x7,(x3): fwd_sel 01
    step();
    drive(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);   // add x8,x7
    ext_hold = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL hold_stall_entry: got %b want %b", stall, 1'b1); end
    for (int unsigned c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (fwd_sel !== 4'b0001) begin n_bad++; $display("FAIL hold_fwd_sel[%0d]: got %b want %b", c, fwd_sel, 4'b0001); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL hold_stall_cnt[%0d]: got %0d want %0d", c, stall_cnt, 0); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL hold_stall[%0d]: got %b want %b", c, stall, 1'b1); end
    end
    ext_hold = 1'b0;
    step();
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL hold_release_cnt: got %0d want %0d", stall_cnt, 1); end
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL hold_release_bubble: got %b want %b", fwd_sel, 4'b0000); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hold_release_stall: got %b want %b", stall, 1'b0); end
    step();
    n_cmp++; if (fwd_sel !== 4'b0010) begin n_bad++; $display("FAIL hold_consumer_fwd_sel: got %b want %b", fwd_sel, 4'b0010); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int unsigned t;
    int unsigned exp_cnt;
    int unsigned more;
    do_reset();
    big_id_valid    = 1'b1;                        // lw x7,(x7) held in decode
    big_id_rs       = {5'd0, 5'd7};
    big_id_rd       = 5'd7;
    big_id_regwrite = 1'b1;
    big_id_memtoreg = 1'b1;
    step();                                        // first load enters
    t = 1;
    exp_cnt = 0;
    // At cycle t the in-flight load sits at stage (t-1) mod 32; it
    // stalls decode while that stage is 0..30.
    while (exp_cnt < 65534) begin
      if (((t - 1) % 32) != 31) exp_cnt++;
      step();
      t++;
      if (t == 33) begin
        n_cmp++; if (big_fwd_sel !== 12'd32) begin n_bad++; $display("FAIL sat_deep_fwd_sel: got %0d want %0d", big_fwd_sel, 32); end
      end
    end
    n_cmp++; if (big_stall_cnt !== 16'd65534) begin n_bad++; $display("FAIL sat_preload_cnt: got %0d want %0d", big_stall_cnt, 65534); end
    more = 0;
    while (more < 3) begin
      if (((t - 1) % 32) != 31) more++;
      step();
      t++;
    end
    n_cmp++; if (big_stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want %h", big_stall_cnt, 16'hFFFF); end
    big_id_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    ext_hold        = 1'b0;
    flush           = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    big_id_valid    = 1'b0;
    big_id_rs       = '0;
    big_id_rd       = '0;
    big_id_regwrite = 1'b0;
    big_id_memtoreg = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_nearest();
    test_reg0();
    test_flush();
    test_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
